// File: rtl/sprite_draw_arbiter_if.sv
// Bundle between the sprite control blocks and the plotter arbiter: the move
// requests, the sprite geometry, and the registered VGA pixel write port.
interface sprite_draw_arbiter_if;
  logic       load_level;
  logic       player_move;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic       enemy_move;
  logic [7:0] enemy_x;
  logic [6:0] enemy_y;
  logic [2:0] enemy_width;
  logic [2:0] enemy_colour;
  logic       bullet_move;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;

  modport master (
    output load_level, player_move, player_x, player_y,
    output enemy_move, enemy_x, enemy_y, enemy_width, enemy_colour,
    output bullet_move, bullet_x, bullet_y,
    input  vga_x, vga_y, vga_colour, plot, busy
  );

  modport slave (
    input  load_level, player_move, player_x, player_y,
    input  enemy_move, enemy_x, enemy_y, enemy_width, enemy_colour,
    input  bullet_move, bullet_x, bullet_y,
    output vga_x, vga_y, vga_colour, plot, busy
  );
endinterface

// File: rtl/sprite_draw_arbiter.sv
// Round-robin owner of the single VGA plotter port: erases and redraws the
// player, enemy and bullet one pixel per clock, and clears the screen on load_level.
module sprite_draw_arbiter #(
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  parameter int         PLAYER_W      = 3,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] PLAYER_COLOUR = 3'b010,
  parameter logic [2:0] BULLET_COLOUR = 3'b111
) (
  input logic                  clk,
  input logic                  resetn,
  sprite_draw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, ERASE, DRAW} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_pending, r_valid;
  logic [1:0] r_last, r_sel;
  logic [7:0] r_col;
  logic [6:0] r_row;
  logic [7:0] r_new_x;
  logic [6:0] r_new_y;
  logic [2:0] r_new_w, r_new_col;
  logic [7:0] r_old_x [0:2];
  logic [6:0] r_old_y [0:2];
  logic [2:0] r_old_w [0:2];
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_col;
  logic       r_plot;

  logic [2:0] w_moves, w_gmask;
  logic [1:0] w_c0, w_c1, w_c2, w_gidx;
  logic       w_grant;
  logic [7:0] w_g_x;
  logic [6:0] w_g_y;
  logic [2:0] w_g_w, w_g_col;
  logic [7:0] w_base_x, w_span_w;
  logic [6:0] w_base_y, w_span_h;
  logic [2:0] w_colour;
  logic       w_scan, w_last_col, w_last_row, w_last_pix, w_onscreen;
  logic [8:0] w_px;
  logic [7:0] w_py;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] clamp_width(input logic [2:0] w);
    return (w == 3'd0) ? 3'd1 : w;
  endfunction

  assign w_moves = {bus.bullet_move, bus.enemy_move, bus.player_move};
  assign w_c0    = rr_next(r_last);
  assign w_c1    = rr_next(w_c0);
  assign w_c2    = rr_next(w_c1);
  assign w_grant = (r_state == IDLE) && !bus.load_level && (r_pending != 3'b000);
  assign w_gmask = w_grant ? (3'b001 << w_gidx) : 3'b000;

  always_comb begin
    w_gidx = w_c2;
    if (r_pending[w_c0])      w_gidx = w_c0;
    else if (r_pending[w_c1]) w_gidx = w_c1;
  end

  always_comb begin
    w_g_x   = r_new_x;
    w_g_y   = r_new_y;
    w_g_w   = 3'd1;
    w_g_col = BULLET_COLOUR;
    case (w_gidx)
      2'd0: begin
        w_g_x = bus.player_x; w_g_y = bus.player_y;
        w_g_w = 3'(PLAYER_W); w_g_col = PLAYER_COLOUR;
      end
      2'd1: begin
        w_g_x = bus.enemy_x; w_g_y = bus.enemy_y;
        w_g_w = clamp_width(bus.enemy_width); w_g_col = bus.enemy_colour;
      end
      default: begin
        w_g_x = bus.bullet_x; w_g_y = bus.bullet_y;
        w_g_w = 3'd1; w_g_col = BULLET_COLOUR;
      end
    endcase
  end

  // Scan geometry: the whole screen, the old rectangle, or the latched new one.
  always_comb begin
    w_base_x = r_new_x;
    w_base_y = r_new_y;
    w_span_w = {5'b0, r_new_w};
    w_span_h = {4'b0, r_new_w};
    w_colour = r_new_col;
    case (r_state)
      CLEAR: begin
        w_base_x = 8'd0; w_base_y = 7'd0;
        w_span_w = 8'(SCREEN_W); w_span_h = 7'(SCREEN_H);
        w_colour = BG_COLOUR;
      end
      ERASE: begin
        w_base_x = r_old_x[r_sel]; w_base_y = r_old_y[r_sel];
        w_span_w = {5'b0, r_old_w[r_sel]}; w_span_h = {4'b0, r_old_w[r_sel]};
        w_colour = BG_COLOUR;
      end
      default: ;
    endcase
  end

  assign w_scan     = (r_state != IDLE);
  assign w_last_col = (r_col == w_span_w - 8'd1);
  assign w_last_row = (r_row == w_span_h - 7'd1);
  assign w_last_pix = w_scan && w_last_col && w_last_row;
  assign w_px       = {1'b0, w_base_x} + {1'b0, r_col};
  assign w_py       = {1'b0, w_base_y} + {1'b0, r_row};
  assign w_onscreen = (w_px < 9'(SCREEN_W)) && (w_py < 8'(SCREEN_H));

  always_comb begin
    w_state_nxt = r_state;
    if (bus.load_level) begin
      w_state_nxt = CLEAR;
    end else begin
      case (r_state)
        IDLE:    if (w_grant) w_state_nxt = r_valid[w_gidx] ? ERASE : DRAW;
        CLEAR:   if (w_last_pix) w_state_nxt = IDLE;
        ERASE:   if (w_last_pix) w_state_nxt = DRAW;
        DRAW:    if (w_last_pix) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 3'b000;
      r_valid   <= 3'b000;
      r_last    <= 2'd2;
      r_col     <= 8'd0;
      r_row     <= 7'd0;
      r_vga_x   <= 8'd0;
      r_vga_y   <= 7'd0;
      r_vga_col <= 3'd0;
      r_plot    <= 1'b0;
    end else begin
      if (bus.load_level) begin
        r_pending <= 3'b000;
        r_valid   <= 3'b000;
      end else if (r_state == CLEAR) begin
        if (w_last_pix) r_pending <= 3'b111;
      end else begin
        r_pending <= (r_pending & ~w_gmask) | w_moves;
        if (r_state == DRAW && w_last_pix) r_valid <= r_valid | (3'b001 << r_sel);
      end

      if (w_grant) r_last <= w_gidx;

      // Counters wrap to zero on the last pixel, so ERASE flows straight into DRAW.
      if (bus.load_level || !w_scan) begin
        r_col <= 8'd0;
        r_row <= 7'd0;
      end else if (w_last_col) begin
        r_col <= 8'd0;
        r_row <= w_last_row ? 7'd0 : r_row + 7'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end

      if (w_scan && !bus.load_level) begin
        r_vga_x   <= w_px[7:0];
        r_vga_y   <= w_py[6:0];
        r_vga_col <= w_colour;
        r_plot    <= w_onscreen;
      end else begin
        r_plot    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_sel     <= w_gidx;
      r_new_x   <= w_g_x;
      r_new_y   <= w_g_y;
      r_new_w   <= w_g_w;
      r_new_col <= w_g_col;
    end
    if (r_state == DRAW && w_last_pix && !bus.load_level) begin
      r_old_x[r_sel] <= r_new_x;
      r_old_y[r_sel] <= r_new_y;
      r_old_w[r_sel] <= r_new_w;
    end
  end

  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_col;
  assign bus.plot       = r_plot;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Randomised and directed bench for sprite_draw_arbiter against a pixel-queue
// reference model: each grant or clear expands into the list of pixel cycles it must emit.
`timescale 1ns/1ps
module tb_sprite_draw_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sprite_draw_arbiter_if bus();
  sprite_draw_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct { bit plot; int x; int y; bit [2:0] col; bit last_clear; } pix_t;

  pix_t     exp_q[$];
  pix_t     m_cur;
  bit [2:0] m_pend, m_valid;
  bit       m_clearing, m_busy;
  int       m_last;
  int       m_old_x[3], m_old_y[3], m_old_w[3];
  int       n_chk = 0, n_pass = 0, n_plots = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic void push_rect(input int x, input int y, input int w, input bit [2:0] col);
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++) begin
        pix_t p;
        p.plot = (x + c < 160) && (y + r < 120);
        p.x = x + c; p.y = y + r; p.col = col; p.last_clear = 1'b0;
        exp_q.push_back(p);
      end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_pend = 3'b000; m_valid = 3'b000; m_last = 2;
    m_clearing = 1'b0; m_busy = 1'b0;
    m_cur = '{plot:1'b0, x:0, y:0, col:3'd0, last_clear:1'b0};
  endfunction

  // One clock edge of the reference: returns the pixel that must appear after it.
  function automatic void model_step();
    bit [2:0] mv, pend_old, gmask;
    bit       was_clr;
    pix_t     idle;
    idle     = '{plot:1'b0, x:0, y:0, col:3'd0, last_clear:1'b0};
    mv       = {bus.bullet_move, bus.enemy_move, bus.player_move};
    pend_old = m_pend;
    was_clr  = m_clearing;
    gmask    = 3'b000;
    if (bus.load_level) begin
      exp_q.delete();
      m_pend = 3'b000; m_valid = 3'b000; m_clearing = 1'b1; m_cur = idle;
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++) begin
          pix_t p;
          p.plot = 1'b1; p.x = x; p.y = y; p.col = 3'd0;
          p.last_clear = (x == 159) && (y == 119);
          exp_q.push_back(p);
        end
    end else begin
      if (exp_q.size() == 0) begin
        m_cur = idle;
        if (pend_old != 3'b000) begin
          int sel = -1;
          int gx, gy, gw;
          bit [2:0] gc;
          for (int k = 1; k <= 3; k++)
            if (sel < 0 && pend_old[(m_last + k) % 3]) sel = (m_last + k) % 3;
          case (sel)
            0: begin gx = int'(bus.player_x); gy = int'(bus.player_y); gw = 3; gc = 3'b010; end
            1: begin
              gx = int'(bus.enemy_x); gy = int'(bus.enemy_y);
              gw = (bus.enemy_width == 3'd0) ? 1 : int'(bus.enemy_width);
              gc = bus.enemy_colour;
            end
            default: begin gx = int'(bus.bullet_x); gy = int'(bus.bullet_y); gw = 1; gc = 3'b111; end
          endcase
          if (m_valid[sel]) push_rect(m_old_x[sel], m_old_y[sel], m_old_w[sel], 3'b000);
          push_rect(gx, gy, gw, gc);
          m_old_x[sel] = gx; m_old_y[sel] = gy; m_old_w[sel] = gw;
          m_valid[sel] = 1'b1; m_last = sel; gmask[sel] = 1'b1;
        end
      end else begin
        m_cur = exp_q.pop_front();
        if (m_cur.last_clear) m_clearing = 1'b0;
      end
      if (was_clr) begin
        if (m_cur.last_clear) m_pend = 3'b111;
      end else begin
        m_pend = (pend_old & ~gmask) | mv;
      end
    end
    m_busy = (exp_q.size() != 0);
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      model_reset();
    end else begin
      model_step();
      #1;
      if (bus.plot) n_plots++;
      check_eq("plot", int'(bus.plot), int'(m_cur.plot));
      check_eq("busy", int'(bus.busy), int'(m_busy));
      if (m_cur.plot) begin
        check_eq("vga_x", int'(bus.vga_x), m_cur.x);
        check_eq("vga_y", int'(bus.vga_y), m_cur.y);
        check_eq("vga_colour", int'(bus.vga_colour), int'(m_cur.col));
      end
    end
  end

  task automatic pulse(input bit p, input bit e, input bit b);
    @(negedge clk);
    bus.player_move = p; bus.enemy_move = e; bus.bullet_move = b;
    @(negedge clk);
    bus.player_move = 1'b0; bus.enemy_move = 1'b0; bus.bullet_move = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && m_pend == 3'b000 && !bus.busy) done = 1'b1;
    end
    check_eq("idle_in_budget", int'(done), 1);
  endtask

  initial begin
    int base;
    bit seen;
    bus.load_level = 1'b0;
    bus.player_move = 1'b0; bus.enemy_move = 1'b0; bus.bullet_move = 1'b0;
    bus.player_x = 8'd0; bus.player_y = 7'd0;
    bus.enemy_x = 8'd0;  bus.enemy_y = 7'd0;
    bus.enemy_width = 3'd4; bus.enemy_colour = 3'b101;
    bus.bullet_x = 8'd0; bus.bullet_y = 7'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_plot", int'(bus.plot), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_vga_x", int'(bus.vga_x), 0);
    check_eq("rst_vga_y", int'(bus.vga_y), 0);
    check_eq("rst_vga_colour", int'(bus.vga_colour), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    bus.player_x = 8'd80; bus.player_y = 7'd115;
    base = n_plots; pulse(1'b1, 1'b0, 1'b0); wait_idle(100);
    check_eq("first_draw_plots", n_plots - base, 9);

    bus.player_x = 8'd79;
    base = n_plots; pulse(1'b1, 1'b0, 1'b0); wait_idle(100);
    check_eq("move_plots", n_plots - base, 18);

    bus.enemy_x = 8'd40; bus.enemy_y = 7'd40;
    bus.bullet_x = 8'd10; bus.bullet_y = 7'd20;
    pulse(1'b1, 1'b1, 1'b1); wait_idle(300);

    @(negedge clk); bus.player_move = 1'b1;
    repeat (5) @(negedge clk);
    bus.enemy_move = 1'b1;
    @(negedge clk); bus.enemy_move = 1'b0;
    repeat (40) @(negedge clk);
    bus.player_move = 1'b0;
    wait_idle(300);

    bus.enemy_x = 8'd158; bus.enemy_y = 7'd50;
    base = n_plots; pulse(1'b0, 1'b1, 1'b0); wait_idle(200);
    check_eq("clip_plots", n_plots - base, 24);

    bus.player_x = 8'd20; bus.player_y = 7'd20;
    base = n_plots; pulse(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (n_plots - base >= 11) seen = 1'b1;
    end
    check_eq("reached_draw", int'(seen), 1);
    bus.load_level = 1'b1; base = n_plots;
    @(negedge clk); bus.load_level = 1'b0;
    wait_idle(20000);
    check_eq("clear_then_redraw_plots", n_plots - base, 19218);

    @(negedge clk); bus.load_level = 1'b1;
    @(negedge clk); bus.load_level = 1'b0;
    repeat (100) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_rst_plot", int'(bus.plot), 0);
    check_eq("async_rst_busy", int'(bus.busy), 0);
    check_eq("async_rst_vga_x", int'(bus.vga_x), 0);
    check_eq("async_rst_vga_y", int'(bus.vga_y), 0);
    check_eq("async_rst_vga_colour", int'(bus.vga_colour), 0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    bus.bullet_x = 8'd5; bus.bullet_y = 7'd5;
    base = n_plots; pulse(1'b0, 1'b0, 1'b1); wait_idle(50);
    check_eq("post_reset_no_erase", n_plots - base, 1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.player_move  = ($urandom_range(0, 15) == 0);
      bus.enemy_move   = ($urandom_range(0, 15) == 0);
      bus.bullet_move  = ($urandom_range(0, 7) == 0);
      bus.player_x     = 8'($urandom_range(0, 170));
      bus.player_y     = 7'($urandom_range(0, 127));
      bus.enemy_x      = 8'($urandom_range(0, 255));
      bus.enemy_y      = 7'($urandom_range(0, 127));
      bus.enemy_width  = 3'($urandom_range(0, 7));
      bus.enemy_colour = 3'($urandom_range(0, 7));
      bus.bullet_x     = 8'($urandom_range(0, 165));
      bus.bullet_y     = 7'($urandom_range(0, 125));
      bus.load_level   = (i == 300);
    end
    @(negedge clk);
    bus.player_move = 1'b0; bus.enemy_move = 1'b0; bus.bullet_move = 1'b0;
    bus.load_level = 1'b0;
    wait_idle(25000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sprite_draw_arbiter.md
# sprite_draw_arbiter

Shares the single VGA plotter write port between the three moving sprites (player, enemy, bullet). On each sprite's `move` pulse it erases the sprite's previously drawn rectangle in background colour, then draws it at its new coordinates, one pixel per clock. It also performs a full-screen clear on `load_level`. It sits between the player, enemy and bullet control blocks and the VGA adapter.

## Interface
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `PLAYER_W`, 3: player square width.
- `BG_COLOUR`, 3'b000: erase/clear colour.
- `PLAYER_COLOUR`, 3'b010: player colour.
- `BULLET_COLOUR`, 3'b111: bullet colour (bullet is 1x1).

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `load_level` in 1: level-sensitive clear request.
- `player_move` in 1; `player_x` in 8; `player_y` in 7: player move pulse and top-left position.
- `enemy_move` in 1; `enemy_x` in 8; `enemy_y` in 7: enemy move pulse and top-left position.
- `enemy_width` in 3; `enemy_colour` in 3: enemy square width and colour.
- `bullet_move` in 1; `bullet_x` in 8; `bullet_y` in 7: bullet move pulse and position.
- `vga_x` out 8; `vga_y` out 7; `vga_colour` out 3: registered pixel to plot.
- `plot` out 1: registered write strobe, high for exactly one cycle per pixel.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, CLEAR, ERASE, DRAW.
- **Pending flags:** `pending[2:0]` (0 = player, 1 = enemy, 2 = bullet).
  - A flag is set on any edge where its `move` input is high.
  - A flag is cleared on the edge that grants that sprite.
  - If set and clear occur on the same edge, set wins.
- **Grant (IDLE):** round-robin, starting from the index after the last granted one. The last-granted pointer resets to 2, so the player goes first.
  - The grant edge latches the sprite's current x, y, width and colour.
  - Width: player = `PLAYER_W`, bullet = 1, enemy = `enemy_width`, with 0 clamped to 1.
- **Old-rectangle records:** each sprite keeps `old_x`, `old_y`, `old_w` and a `valid` bit.
  - If `valid` is set, the sprite goes to ERASE over its old rectangle in `BG_COLOUR`.
  - If `valid` is clear, it goes directly to DRAW.
- **DRAW:** scans the latched rectangle in the latched colour.
  - On the final pixel: old record <= latched values, `valid` <= 1, return to IDLE.
- **Pixel scan:** raster order, column counter inner (0..w-1) and row counter outer.
  - Pixel = base + offset.
  - Any pixel with x >= `SCREEN_W` or y >= `SCREEN_H` still takes its cycle, but with `plot` = 0.
- **CLEAR:**
  - Entry: `load_level` high in any state moves to CLEAR on the next edge. Any in-progress ERASE/DRAW is abandoned, and `pending` and all `valid` bits are cleared.
  - Scan: raster over 160x120 in `BG_COLOUR`.
  - `load_level` still high during CLEAR restarts the scan at (0,0).
  - Move pulses during CLEAR are ignored.
  - On completion: `pending` <= 3'b111, return to IDLE.
- **Colour changes:** an `enemy_colour` change with no move pulse is not redrawn.

## Timing
- **Reset:** while `resetn` is low, asynchronously:
  - state = IDLE, `pending` = 0, `valid` = 0, pointer = 2;
  - `vga_x` = 0, `vga_y` = 0, `vga_colour` = 0, `plot` = 0, `busy` = 0.
- **Grant latency:**
  - Move high in cycle 0, sampled at edge E1 (pending set).
  - IDLE grants at E2 (state -> ERASE/DRAW).
  - First pixel registered at E3; `plot` is high in the cycle after E3.
- **Burst:** erase and draw pixels are contiguous, one per cycle, with no gap between ERASE and DRAW.
  - A sprite with a valid old record of width w occupies 2·w² pixel cycles, plus the grant cycle.
- **Between sprites:** the return to IDLE and the next grant cost exactly one non-plot cycle.
- **Clear:** 19200 consecutive plot cycles; `plot` is high in the cycle after CLEAR is entered.
- **Outputs:** `vga_*` and `plot` change only on clock edges, except for reset.

## Test plan
- **First draw:** release reset; `player_move` pulse at (80,115) -> 9 plots, colour 3'b010, x 80..82, y 115..117, raster order, no erase; `busy` falls afterwards.
- **Move:** then `player_move` at (79,115) -> 9 plots of 3'b000 at x 80..82, then 9 plots of 3'b010 at x 79..81, contiguous.
- **Fairness:** all three move pulses on the same cycle -> service order player, enemy (w=4, 16 draw pixels), bullet. Then with `player_move` held high every cycle and `enemy_move` pulsed -> enemy is served immediately after the current player service.
- **Right-edge clipping:** enemy at x=158, w=4 -> x 158,159 plotted; x 160,161 cycles have `plot` = 0; burst length unchanged.
- **Clear mid-draw:** `load_level` pulsed mid-DRAW -> next edge stops sprite pixels; 19200 `BG_COLOUR` plots (0,0)..(159,119); then player, enemy and bullet drawn with no erase phases.
- **Asynchronous reset:** `resetn` low mid-CLEAR, between edges -> `plot`, `vga_*` and `busy` go to 0 immediately; after release, a move pulse draws without erase.
